axi_rd_mem_responder: RTL and testbench

AXI4 read-only subordinate that answers the instruction-fetch AXI initiator in simulation and FPGA bring-up.
- Backed by a word-addressed memory, preloaded through a backdoor port.
- Accepts one read burst at a time and returns beats on R.
- Sits on the instr AXI bus; the write channels are tied off outside this block.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_burst_addr_next.sv | 46 ++++
 rtl/axi_rd_mem_responder.sv | 153 +++++++++++++++
 tb/tb_axi_rd_mem_responder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and responder state type for the instruction-bus
// memory models.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    // Only 2, 4, 8 and 16 beat wrapping bursts are legal.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_next.sv
// Combinational next-beat address for an AXI burst. The reserved burst type
// behaves as FIXED and an illegal WRAP length behaves as INCR.
module axi_burst_addr_next
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] addr_next
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;
    logic [2:0]        len_log2;

    always_comb begin
        step = ADDR_W'(1) << size;
        incr = addr + step;

        case (len)
            8'd1:    len_log2 = 3'd1;
            8'd3:    len_log2 = 3'd2;
            8'd7:    len_log2 = 3'd3;
            default: len_log2 = 3'd4;
        endcase
        wrap_mask = (step << len_log2) - ADDR_W'(1);

        addr_next = incr;
        case (burst)
            BURST_FIXED: addr_next = addr;
            BURST_INCR:  addr_next = incr;
            BURST_WRAP: begin
                if (wrap_len_ok(len))
                    addr_next = (addr & ~wrap_mask) | (incr & wrap_mask);
                else
                    addr_next = incr;
            end
            default:     addr_next = addr;
        endcase
    end

endmodule

// File: rtl/axi_rd_mem_responder.sv
// AXI4 read-only memory responder for the instruction-fetch bus; one burst
// in flight, one beat every two cycles, backdoor preload port.
//
// state | meaning
// IDLE  | ar__ready high, waiting for a read address
// READ  | memory read with the registered beat address
// RESP  | beat presented on R, held until r__ready
module axi_rd_mem_responder
    import axi_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 128,
    parameter int                ID_W      = 1,
    parameter int                MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar__valid,
    input  logic [ADDR_W-1:0]            ar__addr,
    input  logic [7:0]                   ar__len,
    input  logic [2:0]                   ar__size,
    input  logic [1:0]                   ar__burst,
    input  logic [ID_W-1:0]              ar__id,
    output logic                         ar__ready,
    output logic                         r__valid,
    output logic [DATA_W-1:0]            r__data,
    output logic [1:0]                   r__resp,
    output logic                         r__last,
    output logic [ID_W-1:0]              r__id,
    input  logic                         r__ready,
    input  logic                         init__valid,
    input  logic [$clog2(MEM_WORDS)-1:0] init__addr,
    input  logic [DATA_W-1:0]            init__data
);

    localparam int NB   = DATA_W / 8;
    localparam int LNB  = $clog2(NB);
    localparam int MW_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [ID_W-1:0]   id_q;
    logic              ar_ready_q;
    logic              r_valid_q;

    logic              ar_hs;
    logic              r_hs;
    logic              last_beat;
    logic              below_base;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word_idx;
    logic              slv_err;
    logic              dec_err;
    logic [1:0]        beat_resp;

    assign ar_hs     = ar__valid && ar_ready_q;
    assign r_hs      = r_valid_q && r__ready;
    assign last_beat = (cnt_q == len_q);
    assign ar__ready = ar_ready_q;
    assign r__valid  = r_valid_q;

    axi_burst_addr_next #(.ADDR_W(ADDR_W)) u_addr_next (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .addr_next (addr_next)
    );

    // Borrow out of the base subtraction flags addresses below the window.
    always_comb begin
        {below_base, offset} = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        word_idx  = offset >> LNB;
        slv_err   = (int'(size_q) > LNB) || (burst_q == 2'd3) ||
                    ((burst_q == BURST_WRAP) && !wrap_len_ok(len_q));
        dec_err   = below_base || (word_idx >= ADDR_W'(MEM_WORDS));
        beat_resp = RESP_OKAY;
        if (slv_err)
            beat_resp = RESP_SLVERR;
        else if (dec_err)
            beat_resp = RESP_DECERR;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ar_hs) state_nx = READ;
            READ:    state_nx = RESP;
            RESP:    if (r_hs) state_nx = last_beat ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r__data    <= '0;
            r__resp    <= RESP_OKAY;
            r__last    <= 1'b0;
            r__id      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
        end else begin
            ar_ready_q <= (state_nx == IDLE);
            r_valid_q  <= (state_nx == RESP);
            if (ar_hs) begin
                addr_q  <= ar__addr;
                len_q   <= ar__len;
                size_q  <= ar__size;
                burst_q <= ar__burst;
                id_q    <= ar__id;
                cnt_q   <= '0;
            end
            if (state == READ) begin
                r__data <= (beat_resp == RESP_OKAY) ? mem[word_idx[MW_W-1:0]] : '0;
                r__resp <= beat_resp;
                r__last <= last_beat;
                r__id   <= id_q;
            end
            if ((state == RESP) && r_hs && !last_beat) begin
                addr_q <= addr_next;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end

    // Preload port; a write colliding with a READ-cycle access lands after it.
    always_ff @(posedge clk) begin
        if (init__valid)
            mem[init__addr] <= init__data;
    end

endmodule

// File: tb/tb_axi_rd_mem_responder.sv
// Scoreboard bench for axi_rd_mem_responder: a reference model pushes the
// expected beats of each burst and the R-channel monitor pops and compares.
module tb_axi_rd_mem_responder;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
        logic         id;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ar__valid = 1'b0;
    logic [31:0]  ar__addr = '0;
    logic [7:0]   ar__len = '0;
    logic [2:0]   ar__size = '0;
    logic [1:0]   ar__burst = '0;
    logic [0:0]   ar__id = '0;
    logic         ar__ready;
    logic         r__valid;
    logic [127:0] r__data;
    logic [1:0]   r__resp;
    logic         r__last;
    logic [0:0]   r__id;
    logic         r__ready = 1'b0;
    logic         init__valid = 1'b0;
    logic [11:0]  init__addr = '0;
    logic [127:0] init__data = '0;

    int           checks = 0;
    int           errors = 0;
    beat_t        sb[$];
    logic [127:0] tb_mem [4096];

    always #5 clk = ~clk;

    axi_rd_mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .ar__valid   (ar__valid),
        .ar__addr    (ar__addr),
        .ar__len     (ar__len),
        .ar__size    (ar__size),
        .ar__burst   (ar__burst),
        .ar__id      (ar__id),
        .ar__ready   (ar__ready),
        .r__valid    (r__valid),
        .r__data     (r__data),
        .r__resp     (r__resp),
        .r__last     (r__last),
        .r__id       (r__id),
        .r__ready    (r__ready),
        .init__valid (init__valid),
        .init__addr  (init__addr),
        .init__data  (init__data)
    );

    function automatic logic [127:0] word_val(input int i);
        return {32'h1111_0000 + i, 32'h2222_0000 + i, 32'h3333_0000 + i, 32'h4444_0000 + i};
    endfunction

    // Reference model: beat address from the burst definition, lower wrap bound by modulo.
    task automatic push_expected(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                 input logic [1:0] b, input logic id);
        logic [31:0] step, wb, lb, ba;
        bit          bad_wrap, slv;
        beat_t       e;
        step     = 32'd1 << s;
        bad_wrap = (b == 2'd2) && !(l inside {8'd1, 8'd3, 8'd7, 8'd15});
        slv      = (s > 3'd4) || (b == 2'd3) || bad_wrap;
        for (int i = 0; i <= int'(l); i++) begin
            if (b == 2'd0 || b == 2'd3)
                ba = a;
            else if (b == 2'd2 && !bad_wrap) begin
                wb = step * (32'(l) + 32'd1);
                lb = a - (a % wb);
                ba = lb + ((a - lb + 32'(i) * step) % wb);
            end else
                ba = a + 32'(i) * step;
            e.last = (i == int'(l));
            e.id   = id;
            if (slv) begin
                e.resp = 2'd2;
                e.data = '0;
            end else if ((ba / 32'd16) >= 32'd4096) begin
                e.resp = 2'd3;
                e.data = '0;
            end else begin
                e.resp = 2'd0;
                e.data = tb_mem[ba / 32'd16];
            end
            sb.push_back(e);
        end
    endtask

    task automatic preload(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            @(negedge clk);
            init__valid = 1'b1;
            init__addr  = 12'(i);
            init__data  = word_val(i);
            tb_mem[i]   = word_val(i);
        end
        @(negedge clk);
        init__valid = 1'b0;
    endtask

    task automatic run_burst(input string name, input logic [31:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [1:0] b, input logic id,
                             input bit stall, input bit collide, input logic [11:0] cw,
                             input logic [127:0] cd);
        int          n, cyc, got, idx;
        bit          held;
        beat_t       snap, act, exp;
        logic [3:0]  pat;
        pat  = 4'b1001;
        n    = int'(l) + 1;
        held = 1'b0;
        snap = '0;
        push_expected(a, l, s, b, id);
        @(negedge clk);
        ar__addr = a; ar__len = l; ar__size = s; ar__burst = b; ar__id = id;
        ar__valid = 1'b1;
        cyc = 0;
        while (!ar__ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!ar__ready) begin
            errors++;
            $display("FAIL %s ar_timeout ar__ready=%0b required 1", name, ar__ready);
            ar__valid = 1'b0;
            sb.delete();
            return;
        end
        @(negedge clk);
        ar__valid = 1'b0;
        checks++;
        if (ar__ready !== 1'b0 || r__valid !== 1'b0) begin
            errors++;
            $display("FAIL %s read_cycle ar__ready=%0b r__valid=%0b required 0 0", name, ar__ready, r__valid);
        end
        if (collide) begin
            init__valid = 1'b1;
            init__addr  = cw;
            init__data  = cd;
        end
        @(negedge clk);
        init__valid = 1'b0;
        if (collide) tb_mem[cw] = cd;
        checks++;
        if (r__valid !== 1'b1) begin
            errors++;
            $display("FAIL %s first_latency r__valid=%0b required 1", name, r__valid);
        end
        got = 0; cyc = 0; idx = 0;
        while (got < n && cyc < 300) begin
            if (r__valid) begin
                r__ready = stall ? pat[idx % 4] : 1'b1;
                idx++;
                act = {r__data, r__resp, r__last, r__id};
                if (held) begin
                    checks++;
                    if (act !== snap) begin
                        errors++;
                        $display("FAIL %s stall_stable got %h required %h", name, act, snap);
                    end
                end
                if (r__ready) begin
                    held = 1'b0;
                    got++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra_beat got %h required none", name, act);
                    end else begin
                        exp = sb.pop_front();
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL %s beat%0d data=%h resp=%0d last=%0b id=%0b required data=%h resp=%0d last=%0b id=%0b",
                                     name, got, act.data, act.resp, act.last, act.id,
                                     exp.data, exp.resp, exp.last, exp.id);
                        end
                    end
                end else begin
                    held = 1'b1;
                    snap = act;
                end
            end else
                r__ready = 1'b0;
            @(negedge clk);
            cyc++;
        end
        r__ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s beat_count got %0d required %0d", name, got, n);
        end
        checks++;
        if (ar__ready !== 1'b1 || r__valid !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle ar__ready=%0b r__valid=%0b required 1 0", name, ar__ready, r__valid);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ar__ready !== 1'b0 || r__valid !== 1'b0 || r__last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ar__ready=%0b r__valid=%0b r__last=%0b required 0 0 0", ar__ready, r__valid, r__last);
        end
        checks++;
        if (r__data !== 128'd0 || r__resp !== 2'd0 || r__id !== 1'b0) begin
            errors++;
            $display("FAIL reset_data data=%h resp=%0d id=%0b required 0 0 0", r__data, r__resp, r__id);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ar__ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ar__ready=%0b required 1", ar__ready);
        end
    endtask

    task automatic test_incr();
        run_burst("incr", 32'h0, 8'd3, 3'd4, 2'd1, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_wrap();
        run_burst("wrap", 32'h20, 8'd3, 3'd4, 2'd2, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_fixed();
        run_burst("fixed", 32'h10, 8'd2, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_stall();
        run_burst("stall", 32'h40, 8'd3, 3'd4, 2'd1, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_decerr();
        run_burst("decerr", 32'd4096 * 32'd16 - 32'd16, 8'd1, 3'd4, 2'd1, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_errors();
        run_burst("size_err", 32'h0, 8'd1, 3'd5, 2'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_burst("wrap_len_err", 32'h20, 8'd2, 3'd4, 2'd2, 1'b1, 1'b0, 1'b0, '0, '0);
        run_burst("burst_rsvd", 32'h10, 8'd2, 3'd4, 2'd3, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_back_to_back();
        run_burst("b2b_a", 32'h60, 8'd1, 3'd4, 2'd1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_burst("b2b_b", 32'h38, 8'd7, 3'd3, 2'd2, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_collision();
        run_burst("collide_old", 32'h50, 8'd0, 3'd4, 2'd1, 1'b0, 1'b0, 1'b1, 12'd5, 128'hDEAD_BEEF_0000_0005_CAFE_F00D_1234_5678);
        run_burst("collide_new", 32'h50, 8'd0, 3'd4, 2'd1, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_burst();
        int got, cyc;
        @(negedge clk);
        ar__addr = 32'h0; ar__len = 8'd7; ar__size = 3'd4; ar__burst = 2'd1; ar__id = 1'b1;
        ar__valid = 1'b1;
        cyc = 0;
        while (!ar__ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        ar__valid = 1'b0;
        r__ready  = 1'b1;
        got = 0;
        while (got < 2 && cyc < 100) begin
            if (r__valid) got++;
            @(negedge clk);
            cyc++;
        end
        while (!r__valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (got != 2 || r__valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid third_beat beats=%0d r__valid=%0b required 2 1", got, r__valid);
        end
        r__ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (r__valid !== 1'b0 || ar__ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async r__valid=%0b ar__ready=%0b required 0 0", r__valid, ar__ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ar__ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid release ar__ready=%0b required 1", ar__ready);
        end
        run_burst("after_rst", 32'h10, 8'd3, 3'd4, 2'd1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        preload(0, 16);
        preload(4095, 1);
        test_incr();
        test_wrap();
        test_fixed();
        test_stall();
        test_decerr();
        test_errors();
        test_back_to_back();
        test_collision();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
